// File: rtl/pulse_qual_if.sv
// Signal bundle between a pulse source / timebase and the pulse qualifier.
// The master side drives the pulse and tick; the slave side reports results.
interface pulse_qual_if #(
  parameter int W = 4
) ();
  logic         tick;
  logic         a;
  logic         valid;
  logic [W-1:0] width;
  logic         err_short;
  logic         err_long;
  logic         busy;

  modport master (
    output tick,
    output a,
    input  valid,
    input  width,
    input  err_short,
    input  err_long,
    input  busy
  );

  modport slave (
    input  tick,
    input  a,
    output valid,
    output width,
    output err_short,
    output err_long,
    output busy
  );
endinterface

// File: rtl/pulse_qual.sv
// Pulse-width qualifier: measures high pulses on an asynchronous input in ticks
// and strobes valid / err_short / err_long against an inclusive MIN..MAX window.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_WAIT_LOW | after reset, wait for a_s low so a pulse already in progress is ignored
// S_IDLE     | input low, waiting for a rising edge
// S_MEASURE  | pulse high, counting ticks
// S_LONG     | pulse exceeded MAX, count frozen, waiting for the fall silently
module pulse_qual #(
  parameter int MIN  = 2,
  parameter int MAX  = 10,
  parameter int SYNC = 2
) (
  input  logic         clk,
  input  logic         rst,
  pulse_qual_if.slave  pq
);

  localparam int W = $clog2(MAX + 2);
  localparam logic [W-1:0] MIN_W    = W'(MIN);
  localparam logic [W-1:0] MAX_P1_W = W'(MAX + 1);

  typedef enum logic [1:0] {
    S_WAIT_LOW = 2'd0,
    S_IDLE     = 2'd1,
    S_MEASURE  = 2'd2,
    S_LONG     = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [SYNC-1:0] sync_q, sync_d;
  logic            a_prev_q, a_prev_d;
  logic [W-1:0]    cnt_q, cnt_d;
  logic [W-1:0]    width_q, width_d;
  logic            valid_q, valid_d;
  logic            err_short_q, err_short_d;
  logic            err_long_q, err_long_d;
  logic            busy_q, busy_d;

  logic            a_s;
  logic            rise;
  logic            fall;
  logic [W-1:0]    cnt_inc;
  logic            hit_long;

  // Synchronizer chain and edge detection; everything downstream sees a_s only.
  always_comb begin
    sync_d   = {sync_q[SYNC-2:0], pq.a};
    a_prev_d = a_s;
  end

  assign a_s      = sync_q[SYNC-1];
  assign rise     = a_s & ~a_prev_q;
  assign fall     = ~a_s & a_prev_q;
  assign cnt_inc  = cnt_q + 1'b1;
  assign hit_long = pq.tick & (cnt_inc == MAX_P1_W);

  // State register together with the counter, result and strobe flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_WAIT_LOW;
      sync_q      <= '1;
      a_prev_q    <= 1'b1;
      cnt_q       <= '0;
      width_q     <= '0;
      valid_q     <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      a_prev_q    <= a_prev_d;
      cnt_q       <= cnt_d;
      width_q     <= width_d;
      valid_q     <= valid_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      busy_q      <= busy_d;
    end
  end

  // Next state and counter. A fall takes priority over a coincident tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_WAIT_LOW: begin
        if (!a_s) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (rise) begin
          cnt_d   = '0;
          state_d = S_MEASURE;
        end
      end
      S_MEASURE: begin
        if (fall) begin
          state_d = S_IDLE;
        end else if (pq.tick) begin
          cnt_d = cnt_inc;
          if (hit_long) state_d = S_LONG;
        end
      end
      S_LONG: begin
        if (fall) state_d = S_IDLE;
      end
      default: state_d = S_WAIT_LOW;
    endcase
  end

  // Registered strobes and width; strobes only leave MEASURE, so they are exclusive.
  always_comb begin
    valid_d     = 1'b0;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
    width_d     = width_q;
    if (state_q == S_MEASURE) begin
      if (fall) begin
        if (cnt_q < MIN_W) begin
          err_short_d = 1'b1;
        end else begin
          valid_d = 1'b1;
          width_d = cnt_q;
        end
      end else if (hit_long) begin
        err_long_d = 1'b1;
      end
    end
    busy_d = (state_d == S_MEASURE) || (state_d == S_LONG);
  end

  assign pq.valid     = valid_q;
  assign pq.width     = width_q;
  assign pq.err_short = err_short_q;
  assign pq.err_long  = err_long_q;
  assign pq.busy      = busy_q;

endmodule

// File: tb/tb_pulse_qual.sv
// Bench for pulse_qual: directed scenarios with tick every 4th clk, then random
// pulses and ticks compared cycle by cycle against a pulse-level reference model.
module tb_pulse_qual;

  localparam int MIN  = 2;
  localparam int MAX  = 10;
  localparam int SYNC = 2;
  localparam int W    = $clog2(MAX + 2);
  localparam int NH   = 8192;

  logic clk;
  logic rst;
  int   cyc;
  bit   tick_rand;
  int   n_chk;
  int   n_pass;
  logic [W-1:0] last_w;

  bit           a_h  [NH];
  bit           t_h  [NH];
  logic         v_h  [NH];
  logic         es_h [NH];
  logic         el_h [NH];
  logic         b_h  [NH];
  logic [W-1:0] w_h  [NH];

  pulse_qual_if #(.W(W)) pq ();

  pulse_qual #(.MIN(MIN), .MAX(MAX), .SYNC(SYNC)) dut (
    .clk (clk),
    .rst (rst),
    .pq  (pq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Trace recorder: inputs seen at edge n, outputs sampled 1 time unit after it.
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      a_h[cyc] = pq.a;
      t_h[cyc] = pq.tick;
      #1;
      v_h[cyc]  = pq.valid;
      es_h[cyc] = pq.err_short;
      el_h[cyc] = pq.err_long;
      b_h[cyc]  = pq.busy;
      w_h[cyc]  = pq.width;
      cyc++;
    end
  end

  // Timebase: tick on every edge whose index is a multiple of 4, or random.
  initial begin
    pq.tick = 1'b0;
    forever begin
      @(negedge clk);
      pq.tick = tick_rand ? ($urandom_range(0, 2) == 0) : (cyc % 4 == 0);
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  // Raise a at the first edge with index%4==ph, hold hi edges, then 8 low edges.
  task automatic run_pulse(input int hi, input int ph, output int k);
    while (cyc % 4 != ph) @(negedge clk);
    k = cyc;
    pq.a = 1'b1;
    repeat (hi) @(negedge clk);
    pq.a = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    int s, k, quiet, nv;
    rst = 1'b1;
    pq.a = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (pq.valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", pq.valid); else n_pass++;
    n_chk++; if (pq.err_short !== 1'b0) $display("FAIL rst_err_short: got %b expected 0", pq.err_short); else n_pass++;
    n_chk++; if (pq.err_long !== 1'b0) $display("FAIL rst_err_long: got %b expected 0", pq.err_long); else n_pass++;
    n_chk++; if (pq.busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", pq.busy); else n_pass++;
    n_chk++; if (pq.width !== '0) $display("FAIL rst_width: got %0d expected 0", pq.width); else n_pass++;
    rst = 1'b0;
    s = cyc;
    repeat (40) @(negedge clk);
    pq.a = 1'b0;
    repeat (8) @(negedge clk);
    quiet = 0;
    for (int n = s; n < cyc; n++) quiet += int'(v_h[n] | es_h[n] | el_h[n] | b_h[n]);
    n_chk++; if (quiet != 0) $display("FAIL held_at_reset_quiet: got %0d active cycles expected 0", quiet); else n_pass++;
    run_pulse(20, 3, k);
    nv = 0;
    for (int n = k; n < cyc; n++) nv += int'(v_h[n]);
    n_chk++; if (nv != 1) $display("FAIL first_pulse_valid_count: got %0d expected 1", nv); else n_pass++;
    n_chk++; if (v_h[k+22] !== 1'b1) $display("FAIL first_pulse_valid_time: got %b expected 1", v_h[k+22]); else n_pass++;
    n_chk++; if (w_h[k+22] !== W'(5)) $display("FAIL first_pulse_width: got %0d expected 5", w_h[k+22]); else n_pass++;
    last_w = W'(5);
  endtask

  task automatic test_min_boundary();
    int k, nv, ns;
    run_pulse(4, 3, k);
    nv = 0; ns = 0;
    for (int n = k; n < cyc; n++) begin nv += int'(v_h[n]); ns += int'(es_h[n]); end
    n_chk++; if (ns != 1 || es_h[k+6] !== 1'b1) $display("FAIL one_tick_err_short: got count %0d at_F %b expected 1 1", ns, es_h[k+6]); else n_pass++;
    n_chk++; if (nv != 0) $display("FAIL one_tick_no_valid: got %0d expected 0", nv); else n_pass++;
    n_chk++; if (pq.width !== last_w) $display("FAIL one_tick_width_held: got %0d expected %0d", pq.width, last_w); else n_pass++;
    run_pulse(8, 3, k);
    n_chk++; if (v_h[k+10] !== 1'b1 || w_h[k+10] !== W'(2)) $display("FAIL two_tick_valid: got valid %b width %0d expected 1 2", v_h[k+10], w_h[k+10]); else n_pass++;
    last_w = W'(2);
  endtask

  task automatic test_max_long();
    int k, nl, nother, blow;
    run_pulse(40, 3, k);
    n_chk++; if (v_h[k+42] !== 1'b1 || w_h[k+42] !== W'(10)) $display("FAIL ten_tick_valid: got valid %b width %0d expected 1 10", v_h[k+42], w_h[k+42]); else n_pass++;
    last_w = W'(10);
    run_pulse(60, 3, k);
    nl = 0; nother = 0; blow = 0;
    for (int n = k; n < cyc; n++) begin nl += int'(el_h[n]); nother += int'(v_h[n] | es_h[n]); end
    for (int n = k + 2; n < k + 62; n++) blow += int'(!b_h[n]);
    n_chk++; if (nl != 1 || el_h[k+45] !== 1'b1) $display("FAIL long_err_long: got count %0d at_11th %b expected 1 1", nl, el_h[k+45]); else n_pass++;
    n_chk++; if (nother != 0) $display("FAIL long_no_other_strobe: got %0d expected 0", nother); else n_pass++;
    n_chk++; if (blow != 0 || b_h[k+62] !== 1'b0) $display("FAIL long_busy: got low_cycles %0d after_fall %b expected 0 0", blow, b_h[k+62]); else n_pass++;
    n_chk++; if (pq.width !== last_w) $display("FAIL long_width_held: got %0d expected %0d", pq.width, last_w); else n_pass++;
  endtask

  task automatic test_tick_align();
    int k;
    run_pulse(19, 3, k);
    n_chk++; if (v_h[k+21] !== 1'b1 || w_h[k+21] !== W'(4)) $display("FAIL fall_on_tick: got valid %b width %0d expected 1 4", v_h[k+21], w_h[k+21]); else n_pass++;
    run_pulse(12, 2, k);
    n_chk++; if (v_h[k+14] !== 1'b1 || w_h[k+14] !== W'(2)) $display("FAIL rise_on_tick: got valid %b width %0d expected 1 2", v_h[k+14], w_h[k+14]); else n_pass++;
    last_w = W'(2);
  endtask

  task automatic test_reset_mid();
    int k, k2, act, busy_seen;
    while (cyc % 4 != 3) @(negedge clk);
    k = cyc;
    pq.a = 1'b1;
    while (cyc != k + 27) @(negedge clk);
    n_chk++; if (b_h[k+26] !== 1'b1) $display("FAIL mid_busy_before_rst: got %b expected 1", b_h[k+26]); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    n_chk++; if (pq.width !== '0) $display("FAIL mid_rst_width: got %0d expected 0", pq.width); else n_pass++;
    pq.a = 1'b0;
    repeat (8) @(negedge clk);
    act = 0; busy_seen = 0;
    for (int n = k + 27; n < cyc; n++) begin act += int'(v_h[n] | es_h[n] | el_h[n]); busy_seen += int'(b_h[n]); end
    n_chk++; if (act != 0) $display("FAIL mid_rst_no_strobe: got %0d expected 0", act); else n_pass++;
    n_chk++; if (busy_seen != 0) $display("FAIL mid_rst_busy_low: got %0d busy cycles expected 0", busy_seen); else n_pass++;
    run_pulse(12, 3, k2);
    n_chk++; if (v_h[k2+14] !== 1'b1 || w_h[k2+14] !== W'(3)) $display("FAIL after_rst_pulse: got valid %b width %0d expected 1 3", v_h[k2+14], w_h[k2+14]); else n_pass++;
    last_w = W'(3);
  endtask

  task automatic test_back_to_back();
    int k, nv, blow;
    while (cyc % 4 != 3) @(negedge clk);
    k = cyc;
    pq.a = 1'b1;
    repeat (12) @(negedge clk);
    pq.a = 1'b0;
    @(negedge clk);
    pq.a = 1'b1;
    repeat (12) @(negedge clk);
    pq.a = 1'b0;
    repeat (8) @(negedge clk);
    nv = 0; blow = 0;
    for (int n = k; n < cyc; n++) nv += int'(v_h[n]);
    for (int n = k + 2; n < k + 27; n++) blow += int'(!b_h[n]);
    n_chk++; if (nv != 2) $display("FAIL b2b_valid_count: got %0d expected 2", nv); else n_pass++;
    n_chk++; if (v_h[k+14] !== 1'b1 || w_h[k+14] !== W'(3)) $display("FAIL b2b_first: got valid %b width %0d expected 1 3", v_h[k+14], w_h[k+14]); else n_pass++;
    n_chk++; if (v_h[k+27] !== 1'b1 || w_h[k+27] !== W'(3)) $display("FAIL b2b_second: got valid %b width %0d expected 1 3", v_h[k+27], w_h[k+27]); else n_pass++;
    n_chk++; if (blow != 1) $display("FAIL b2b_busy_gap: got %0d low cycles expected 1", blow); else n_pass++;
    last_w = W'(3);
  endtask

  // Random pulses and ticks; the model works from whole pulses seen at the pin:
  // a pulse high on pin edges k..j-1 is recognised at edge k+SYNC and ends at j+SYNC.
  task automatic test_random();
    int s, e, j, r, f, cnt;
    bit lng;
    bit           ev  [NH];
    bit           ees [NH];
    bit           eel [NH];
    bit           eb  [NH];
    int           ew  [NH];
    logic [W-1:0] w;
    tick_rand = 1'b1;
    pq.a = 1'b0;
    repeat (6) @(negedge clk);
    s = cyc;
    for (int p = 0; p < 30; p++) begin
      pq.a = 1'b1;
      repeat ($urandom_range(1, 60)) @(negedge clk);
      pq.a = 1'b0;
      repeat ($urandom_range(1, 8)) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    e = cyc;
    for (int n = s; n < e; n++) begin ev[n] = 0; ees[n] = 0; eel[n] = 0; eb[n] = 0; ew[n] = 0; end
    for (int k = s - SYNC; k < e - SYNC; k++) begin
      if (a_h[k] && !a_h[k-1]) begin
        j = k + 1;
        while (j < e && a_h[j]) j++;
        r = k + SYNC;
        f = j + SYNC;
        cnt = 0;
        lng = 0;
        for (int m = r + 1; m < f; m++) begin
          if (t_h[m] && !lng) begin
            cnt++;
            if (cnt == MAX + 1) begin eel[m] = 1; lng = 1; end
          end
        end
        for (int m = r; m < f; m++) eb[m] = 1;
        if (!lng) begin
          if (cnt < MIN) ees[f] = 1;
          else begin ev[f] = 1; ew[f] = cnt; end
        end
      end
    end
    w = last_w;
    for (int n = s; n < e; n++) begin
      if (ev[n]) w = W'(ew[n]);
      n_chk++;
      if ({v_h[n], es_h[n], el_h[n], b_h[n]} !== {ev[n], ees[n], eel[n], eb[n]} || w_h[n] !== w)
        $display("FAIL random_cycle_%0d: got v/es/el/busy %b%b%b%b width %0d expected %b%b%b%b width %0d",
                 n, v_h[n], es_h[n], el_h[n], b_h[n], w_h[n], ev[n], ees[n], eel[n], eb[n], w);
      else n_pass++;
    end
    tick_rand = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    tick_rand = 1'b0;
    last_w = '0;
    rst = 1'b1;
    pq.a = 1'b1;
    @(negedge clk);
    test_reset();
    test_min_boundary();
    test_max_long();
    test_tick_align();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
